pixel_stream_arbiter: RTL and testbench
=======================================

Name: pixel_stream_arbiter

Overview:
Round-robin, burst-locked arbiter that shares one pixel FIFO (syn_fifo write side) between N_SRC independent pixel_t AXI-stream producers. It sits directly upstream of the FIFO's axis_i and merges the producers onto a single axis_if. Fairness is per burst: a winner holds the grant for up to BURST_LEN accepted beats. A per-source beat counter is provided for debug and verification.

Parameters:
N_SRC, 4, number of requesting streams (2..8)
BURST_LEN, 16, maximum accepted beats per grant (1..256)
CNT_W, 16, width of each per-source accepted-beat counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  arbitration enable; when low, no new grant is issued
axis_i[N_SRC]  slave axis_if  pixel_t  producer streams (data, vld, rdy, ok)
axis_o  master axis_if  pixel_t  merged stream to FIFO axis_i
grant_vld  out  1  a burst grant is active
grant_id  out  $clog2(N_SRC)  index of granted source; valid when grant_vld=1
beat_cnt[N_SRC]  out  CNT_W each  accepted beats per source, wrapping
burst_done  out  1  one-cycle pulse when a grant is released

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, grant_vld=0, grant_id=0.
  - Round-robin pointer last_id=N_SRC-1, so source 0 has first priority.
  - burst counter=0, all beat_cnt=0, burst_done=0.
  - axis_o.vld=0; all axis_i[k].rdy=0.
- FSM with two states, IDLE and GRANT.
- IDLE:
  - If en=1 and any axis_i[k].vld=1, select the first k with vld set, searching last_id+1, last_id+2, ... modulo N_SRC.
  - Register grant_id=k and grant_vld=1; go to GRANT.
  - No data passes in IDLE, so grant latency is 1 cycle from vld to first possible transfer.
- GRANT datapath (combinational, no added latency):
  - axis_o.data = axis_i[grant_id].data.
  - axis_o.vld = axis_i[grant_id].vld.
  - axis_i[grant_id].rdy = axis_o.rdy; every other axis_i[k].rdy=0.
- Accepted beat: axis_o.ok = axis_o.vld & axis_o.rdy. On each accepted beat, increment the burst counter and beat_cnt[grant_id]. beat_cnt wraps modulo 2^CNT_W.
- Release from GRANT to IDLE, decided at the clock edge:
  - (a) The accepted beat makes the burst count equal BURST_LEN, or
  - (b) the granted source shows vld=0 in any GRANT cycle. A gap ends the burst; the FIFO is never held idle for a stalled producer.
- On release:
  - last_id=grant_id, burst counter=0, grant_vld=0, burst_done=1 for one cycle.
  - axis_o.vld drops to 0 in the cycle after release.
- en low during GRANT: the current burst completes normally; no new grant is issued while en=0.
- Backpressure (axis_o.rdy=0, FIFO full):
  - The grant is held, the counter is unchanged and data is held by the producer.
  - A stall alone never releases the grant.
- AXI-stream rules:
  - vld never depends on rdy.
  - The granted source's data and vld pass through unmodified.
  - No beat is duplicated or dropped.
- Single requester: bursts repeat back-to-back with one IDLE cycle between them. Sustained throughput is BURST_LEN/(BURST_LEN+1).
- Simultaneous events: a burst reaching BURST_LEN while vld also drops in the same cycle is a single release with a single burst_done pulse.
- Reset mid-burst:
  - Everything returns to reset values immediately.
  - Any partially transferred burst is abandoned; a beat not yet accepted is not counted.

Test Plan:
- Single source, N_SRC=4, BURST_LEN=4, src2 vld constant, FIFO rdy=1, 10 beats with data 1..10 → bursts of 4, 4, 2.
  - grant_id=2 throughout; one idle cycle between bursts.
  - axis_o data 1..10 in order; beat_cnt[2]=10.
- All four sources requesting continuously → grant order 0, 1, 2, 3, 0, 1, …, each grant exactly 4 beats.
  - burst_done pulses 4 times per round; all beat_cnt equal after 64 beats.
- Backpressure: drive the real syn_fifo (depth 8) with the reader idle until full, src0 and src1 requesting.
  - Transfers stop at 8 beats; grant is held during the stall.
  - After 8 reads: no loss or duplication, output sequence matches a per-source scoreboard.
- Gap release: src1 sends 2 beats then drops vld while src3 requests.
  - grant releases with burst count 2; next grant_id=3; beat_cnt[1]=2.
- en=0 mid-burst of src0 (BURST_LEN=4, 1 beat done) → the burst finishes its remaining 3 beats; grant_vld stays 0 afterwards until en returns to 1, then src1 is granted.
- Async reset (rst=0) asserted between clock edges mid-burst → outputs reach reset values without a clock edge, beat_cnt=0.
  - After rst=1, the first grant goes to source 0.

Source files
------------

// File: rtl/pixel_stream_arbiter_if.sv
// Pixel type and the valid/ready stream interface shared by producers,
// the arbiter and the FIFO write side.
package pixel_pkg;
  typedef logic [23:0] pixel_t;
endpackage

interface axis_if;
  import pixel_pkg::*;
  pixel_t data;
  logic   vld;
  logic   rdy;
  logic   ok;

  // A beat is accepted on any cycle both sides agree.
  assign ok = vld & rdy;

  modport master (output data, output vld, input rdy, input ok);
  modport slave  (input data, input vld, input ok, output rdy);
endinterface

// File: rtl/pixel_stream_arbiter.sv
// Round-robin, burst-locked arbiter merging N_SRC pixel streams onto one
// FIFO write port; the grant holds for up to BURST_LEN beats or until a gap.
module psa_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             vld,
  input  logic             o_rdy,
  output logic             rdy,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign rdy = sel & o_rdy;
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (rdy && vld) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

module pixel_stream_arbiter
  import pixel_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  axis_if.slave                           axis_i [N_SRC],
  axis_if.master                          axis_o,
  output logic                            grant_vld,
  output logic [$clog2(N_SRC)-1:0]        grant_id,
  output logic [N_SRC-1:0][CNT_W-1:0]     beat_cnt,
  output logic                            burst_done
);
  localparam int ID_W = $clog2(N_SRC);
  localparam int BC_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic            done_q, done_d;

  logic [N_SRC-1:0] src_vld;
  logic [N_SRC-1:0] src_rdy;
  pixel_t           src_data [N_SRC];
  logic             sel_vld;
  logic             o_vld;
  logic             beat;
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;

  for (genvar g = 0; g < N_SRC; g++) begin : g_lane
    assign src_vld[g]   = axis_i[g].vld;
    assign src_data[g]  = axis_i[g].data;
    assign axis_i[g].rdy = src_rdy[g];

    psa_lane #(.CNT_W(CNT_W)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .sel   ((state_q == GRANT) && (gid_q == ID_W'(g))),
      .vld   (src_vld[g]),
      .o_rdy (axis_o.rdy),
      .rdy   (src_rdy[g]),
      .cnt   (beat_cnt[g])
    );
  end

  // Pure pass-through of the granted source; vld never looks at rdy.
  assign sel_vld     = src_vld[gid_q];
  assign o_vld       = (state_q == GRANT) & sel_vld;
  assign axis_o.vld  = o_vld;
  assign axis_o.data = src_data[gid_q];
  assign beat        = o_vld & axis_o.rdy;

  assign grant_vld  = (state_q == GRANT);
  assign grant_id   = gid_q;
  assign burst_done = done_q;

  // First requester after the previous winner, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = (int'(last_q) + i) % N_SRC;
      if (!pick_found && src_vld[idx]) begin
        pick_found = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          state_d = GRANT;
          gid_d   = pick_id;
        end
      end
      GRANT: begin
        if (beat) bcnt_d = bcnt_q + BC_W'(1);
        // A gap or a full burst ends the grant; a stall alone does not.
        if (!sel_vld || (beat && (bcnt_q == BC_W'(BURST_LEN - 1)))) begin
          state_d = IDLE;
          last_d  = gid_q;
          bcnt_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gid_q   <= '0;
      last_q  <= ID_W'(N_SRC - 1);
      bcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_pixel_stream_arbiter.sv
// Directed bench for pixel_stream_arbiter: N_SRC=4, BURST_LEN=4, with
// counting producers and a depth-8 FIFO model on the output.
module tb_pixel_stream_arbiter;
  import pixel_pkg::*;

  localparam int N  = 4;
  localparam int BL = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  axis_if src_if [N] ();
  axis_if o_if ();

  logic                 gv;
  logic [1:0]           gid;
  logic [N-1:0][CW-1:0] bc;
  logic                 bd;

  pixel_stream_arbiter #(.N_SRC(N), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .axis_i     (src_if),
    .axis_o     (o_if),
    .grant_vld  (gv),
    .grant_id   (gid),
    .beat_cnt   (bc),
    .burst_done (bd)
  );

  bit   s_on   [N];
  int   s_left [N];
  int   s_sent [N];
  int   s_base [N];
  logic [N-1:0] s_vld, s_rdy;

  for (genvar g = 0; g < N; g++) begin : g_src
    assign s_vld[g]         = s_on[g] && (s_left[g] > 0);
    assign src_if[g].vld    = s_vld[g];
    assign src_if[g].data   = pixel_t'(s_base[g] + s_sent[g]);
    assign s_rdy[g]         = src_if[g].rdy;
  end

  bit fifo_mode, rdy_force, rd_en;
  int fifo_cnt;
  assign o_if.rdy = fifo_mode ? (fifo_cnt < 8) : rdy_force;

  int     total, bad;
  int     done_n;
  bit     gv_prev;
  int     grants [$];
  pixel_t out_q  [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+2: sample mid-cycle, then advance producers/FIFO.
  task automatic cyc();
    logic [N-1:0] hs;
    logic acc;
    #2;
    hs  = s_vld & s_rdy;
    acc = o_if.vld & o_if.rdy;
    if (acc) out_q.push_back(o_if.data);
    if (gv && !gv_prev) grants.push_back(int'(gid));
    gv_prev = gv;
    if (bd) done_n++;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k]) begin s_sent[k]++; s_left[k]--; end
    if (rd_en && fifo_cnt > 0) fifo_cnt--;
    if (acc) fifo_cnt++;
    #1;
  endtask

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin s_on[k] = 0; s_left[k] = 0; s_sent[k] = 0; s_base[k] = 0; end
    out_q.delete(); grants.delete();
    done_n = 0; gv_prev = 0; fifo_cnt = 0; fifo_mode = 0; rd_en = 0; rdy_force = 1;
    rst = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp_seq [2];
    int src;
    total = 0; bad = 0; done_n = 0; gv_prev = 0;
    fifo_mode = 0; rdy_force = 1; rd_en = 0; fifo_cnt = 0;
    for (int k = 0; k < N; k++) begin s_on[k] = 0; s_left[k] = 0; s_sent[k] = 0; s_base[k] = 0; end

    // Reset values
    #1 rst = 1'b0;
    #1;
    chk("rst_gv", gv, 0);
    chk("rst_gid", gid, 0);
    chk("rst_done", bd, 0);
    chk("rst_ovld", o_if.vld, 0);
    chk("rst_srdy", s_rdy, 0);
    chk("rst_cnt", bc, 0);
    #8 rst = 1'b1;
    @(posedge clk);
    #2;

    // Single source: 10 beats as bursts 4,4,2 with one idle cycle between
    en = 1; s_on[2] = 1; s_left[2] = 10; s_base[2] = 1;
    n = 0;
    while (out_q.size() < 10 && n < 60) begin cyc(); n++; end
    chk("t1_beats", out_q.size(), 10);
    chk("t1_span", n, 13);
    repeat (3) cyc();
    for (int i = 0; i < 10; i++) chk("t1_data", out_q[i], i + 1);
    chk("t1_cnt2", bc[2], 10);
    chk("t1_ngrant", grants.size(), 3);
    for (int i = 0; i < grants.size(); i++) chk("t1_gid", grants[i], 2);
    chk("t1_done", done_n, 3);

    // All four sources: strict 0,1,2,3 rotation, four beats each
    do_reset();
    for (int k = 0; k < N; k++) begin s_on[k] = 1; s_left[k] = 100; s_base[k] = k << 8; end
    n = 0;
    while (out_q.size() < 64 && n < 200) begin cyc(); n++; end
    chk("t2_beats", out_q.size(), 64);
    cyc();
    for (int i = 0; i < 64; i++)
      chk("t2_data", out_q[i], (((i / 4) % 4) << 8) | ((i / 16) * 4 + (i % 4)));
    chk("t2_ngrant", grants.size(), 16);
    for (int i = 0; i < grants.size(); i++) chk("t2_order", grants[i], i % 4);
    chk("t2_done", done_n, 16);
    for (int k = 0; k < N; k++) chk("t2_cnt", bc[k], 16);

    // Backpressure into a depth-8 FIFO with the reader idle
    do_reset();
    fifo_mode = 1;
    s_on[0] = 1; s_left[0] = 20; s_base[0] = 0;
    s_on[1] = 1; s_left[1] = 20; s_base[1] = 256;
    repeat (25) cyc();
    chk("t3_stop", out_q.size(), 8);
    chk("t3_full", fifo_cnt, 8);
    chk("t3_hold_gv", gv, 1);
    chk("t3_hold_gid", gid, 0);
    chk("t3_ovld", o_if.vld, 1);
    chk("t3_srdy", s_rdy, 0);
    chk("t3_cnt0", bc[0], 4);
    chk("t3_cnt1", bc[1], 4);
    rd_en = 1;
    n = 0;
    while (out_q.size() < 16 && n < 100) begin cyc(); n++; end
    chk("t3_resume", out_q.size(), 16);
    exp_seq[0] = 0; exp_seq[1] = 0;
    for (int i = 0; i < out_q.size(); i++) begin
      src = (int'(out_q[i]) >> 8) & 1;
      chk("t3_sb", out_q[i], (src << 8) | exp_seq[src]);
      exp_seq[src]++;
    end
    chk("t3_total", bc[0] + bc[1], out_q.size());

    // Gap release: src1 sends 2 beats then drops vld, src3 waiting
    do_reset();
    s_on[1] = 1; s_left[1] = 2;  s_base[1] = 'h100;
    s_on[3] = 1; s_left[3] = 10; s_base[3] = 'h300;
    repeat (8) cyc();
    chk("t4_ngrant", grants.size(), 2);
    chk("t4_first", grants[0], 1);
    chk("t4_next", grants[1], 3);
    chk("t4_cnt1", bc[1], 2);
    chk("t4_cnt3", bc[3], 3);
    chk("t4_done", done_n, 1);
    chk("t4_handover", out_q[2], 'h300);

    // en dropped after one beat of src0's burst
    do_reset();
    s_on[0] = 1; s_left[0] = 100; s_base[0] = 0;
    s_on[1] = 1; s_left[1] = 100; s_base[1] = 256;
    cyc(); cyc();
    chk("t5_onebeat", bc[0], 1);
    en = 0;
    repeat (8) cyc();
    chk("t5_cnt0", bc[0], 4);
    chk("t5_cnt1", bc[1], 0);
    chk("t5_idle", gv, 0);
    chk("t5_done", done_n, 1);
    en = 1;
    cyc();
    chk("t5_regrant", gv, 1);
    chk("t5_gid", gid, 1);

    // Asynchronous reset in the middle of src1's burst
    cyc(); cyc();
    chk("t6_pre", bc[1], 2);
    #2 rst = 1'b0;
    #1;
    chk("t6_gv", gv, 0);
    chk("t6_gid", gid, 0);
    chk("t6_done", bd, 0);
    chk("t6_ovld", o_if.vld, 0);
    chk("t6_srdy", s_rdy, 0);
    chk("t6_cnt", bc, 0);
    #1 rst = 1'b1;
    for (int k = 0; k < N; k++) begin s_on[k] = 1; s_left[k] = 100; end
    @(posedge clk);
    #2;
    chk("t6_first_gv", gv, 1);
    chk("t6_first_gid", gid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
